// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the pipelined control unit.
//   - opcode encodings of the supported instruction classes
//   - ALU op class codes carried in the control bundle
//   - control bundle struct; the 9 low bits follow the order
//     {branch, mem_to_reg, reg_write, mem_read, mem_write, alu_src, alu_op}
//     and jump sits above them
//   - forwarding select encodings
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_R    = 7'h33;
    localparam logic [6:0] OP_I    = 7'h13;
    localparam logic [6:0] OP_U    = 7'h37;
    localparam logic [6:0] OP_LOAD = 7'h03;
    localparam logic [6:0] OP_S    = 7'h23;
    localparam logic [6:0] OP_SB   = 7'h63;
    localparam logic [6:0] OP_JAL  = 7'h6F;
    localparam logic [6:0] OP_JALR = 7'h67;

    localparam int ALU_OP_W = 3;

    localparam logic [ALU_OP_W-1:0] ALU_R    = 3'd0;
    localparam logic [ALU_OP_W-1:0] ALU_I    = 3'd1;
    localparam logic [ALU_OP_W-1:0] ALU_U    = 3'd2;
    localparam logic [ALU_OP_W-1:0] ALU_LOAD = 3'd3;
    localparam logic [ALU_OP_W-1:0] ALU_S    = 3'd4;
    localparam logic [ALU_OP_W-1:0] ALU_SB   = 3'd5;
    localparam logic [ALU_OP_W-1:0] ALU_JAL  = 3'd6;
    localparam logic [ALU_OP_W-1:0] ALU_JALR = 3'd7;

    typedef struct packed {
        logic                jump;
        logic                branch;
        logic                mem_to_reg;
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic                alu_src;
        logic [ALU_OP_W-1:0] alu_op;
    } ctrl_t;

    localparam logic [1:0] FWD_RF     = 2'b00;
    localparam logic [1:0] FWD_EX_MEM = 2'b10;
    localparam logic [1:0] FWD_MEM_WB = 2'b01;

endpackage

// File: rtl/control_decoder.sv
// Combinational ID-stage decoder.
// Ports:
//   op        in   7  opcode of the instruction in ID
//   ctrl      out     decoded control bundle
//   rs1_used  out  1  instruction reads rs1
//   rs2_used  out  1  instruction reads rs2
//   illegal   out  1  opcode is not one of the supported classes
module control_decoder
    import riscv_ctrl_pkg::*;
#(
    parameter bit ILLEGAL_AS_NOP = 1'b1
) (
    input  logic [6:0] op,
    output ctrl_t      ctrl,
    output logic       rs1_used,
    output logic       rs2_used,
    output logic       illegal
);

    always_comb begin
        ctrl     = '0;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        illegal  = 1'b0;
        case (op)
            OP_R: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_R;
                rs1_used       = 1'b1;
                rs2_used       = 1'b1;
            end
            OP_I: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_I;
                rs1_used       = 1'b1;
            end
            OP_U: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_U;
            end
            OP_LOAD: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.alu_op     = ALU_LOAD;
                rs1_used        = 1'b1;
            end
            OP_S: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_S;
                rs1_used       = 1'b1;
                rs2_used       = 1'b1;
            end
            OP_SB: begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALU_SB;
                rs1_used    = 1'b1;
                rs2_used    = 1'b1;
            end
            OP_JAL: begin
                ctrl.jump      = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_JAL;
            end
            OP_JALR: begin
                ctrl.jump      = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_JALR;
                rs1_used       = 1'b1;
            end
            default: begin
                illegal = 1'b1;
                // legacy mode drives every control bit high
                if (!ILLEGAL_AS_NOP) ctrl = '1;
            end
        endcase
    end

endmodule

// File: rtl/pipelined_control_unit.sv
// Pipelined control unit: decodes in ID, carries the control bundle through
// ID/EX, EX/MEM and MEM/WB, and produces stall, flush and EX forwarding selects.
// Ports:
//   clk, reset                          clock, async active-low reset
//   op_id_i, rs1_id_i, rs2_id_i, rd_id_i  instruction fields in ID
//   branch_taken_i                      EX branch compare result
//   pc_write_o, if_id_write_o           0 holds PC / IF/ID (load-use stall)
//   if_id_flush_o                       1 loads NOP into IF/ID (taken branch/jump)
//   ex_alu_src_o, ex_alu_op_o, ex_branch_o, ex_jump_o   EX-stage controls
//   fwd_a_o, fwd_b_o                    ALU operand source selects
//   mem_read_o, mem_write_o             MEM-stage controls
//   wb_reg_write_o, wb_mem_to_reg_o, wb_rd_o  WB-stage controls
//   illegal_o                           sticky illegal-opcode flag
module pipelined_control_unit
    import riscv_ctrl_pkg::*;
#(
    parameter int ALU_OP_WIDTH   = 3,
    parameter int REG_ADDR_WIDTH = 5,
    parameter bit ILLEGAL_AS_NOP = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [6:0]                op_id_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_id_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_id_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_id_i,
    input  logic                      branch_taken_i,
    output logic                      pc_write_o,
    output logic                      if_id_write_o,
    output logic                      if_id_flush_o,
    output logic                      ex_alu_src_o,
    output logic [ALU_OP_WIDTH-1:0]   ex_alu_op_o,
    output logic                      ex_branch_o,
    output logic                      ex_jump_o,
    output logic [1:0]                fwd_a_o,
    output logic [1:0]                fwd_b_o,
    output logic                      mem_read_o,
    output logic                      mem_write_o,
    output logic                      wb_reg_write_o,
    output logic                      wb_mem_to_reg_o,
    output logic [REG_ADDR_WIDTH-1:0] wb_rd_o,
    output logic                      illegal_o
);

    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

    ctrl_t     id_ctrl;
    logic      id_rs1_used;
    logic      id_rs2_used;
    logic      id_illegal;
    reg_addr_t id_rd;
    reg_addr_t id_rs1;
    reg_addr_t id_rs2;

    ctrl_t     ex_ctrl;
    reg_addr_t ex_rd;
    reg_addr_t ex_rs1;
    reg_addr_t ex_rs2;

    logic      em_reg_write;
    logic      em_mem_to_reg;
    logic      em_mem_read;
    logic      em_mem_write;
    reg_addr_t em_rd;

    logic      mw_reg_write;
    logic      mw_mem_to_reg;
    reg_addr_t mw_rd;

    logic      illegal_q;
    logic      load_use;
    logic      flush;
    logic      stall;

    control_decoder #(
        .ILLEGAL_AS_NOP (ILLEGAL_AS_NOP)
    ) u_decoder (
        .op       (op_id_i),
        .ctrl     (id_ctrl),
        .rs1_used (id_rs1_used),
        .rs2_used (id_rs2_used),
        .illegal  (id_illegal)
    );

    // An illegal opcode in NOP mode becomes a true bubble, rd included.
    // Unused source fields are zeroed so they can never match a destination.
    assign id_rd  = (id_illegal && ILLEGAL_AS_NOP) ? '0 : rd_id_i;
    assign id_rs1 = id_rs1_used ? rs1_id_i : '0;
    assign id_rs2 = id_rs2_used ? rs2_id_i : '0;

    assign load_use = ex_ctrl.mem_read && (ex_rd != '0) &&
                      ((id_rs1_used && (ex_rd == rs1_id_i)) ||
                       (id_rs2_used && (ex_rd == rs2_id_i)));
    assign flush    = (ex_ctrl.branch && branch_taken_i) || ex_ctrl.jump;
    // a taken redirect discards the dependent instruction, so no hold is needed
    assign stall    = load_use && !flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_ctrl       <= '0;
            ex_rd         <= '0;
            ex_rs1        <= '0;
            ex_rs2        <= '0;
            em_reg_write  <= 1'b0;
            em_mem_to_reg <= 1'b0;
            em_mem_read   <= 1'b0;
            em_mem_write  <= 1'b0;
            em_rd         <= '0;
            mw_reg_write  <= 1'b0;
            mw_mem_to_reg <= 1'b0;
            mw_rd         <= '0;
            illegal_q     <= 1'b0;
        end else begin
            if (stall || flush) begin
                ex_ctrl <= '0;
                ex_rd   <= '0;
                ex_rs1  <= '0;
                ex_rs2  <= '0;
            end else begin
                ex_ctrl <= id_ctrl;
                ex_rd   <= id_rd;
                ex_rs1  <= id_rs1;
                ex_rs2  <= id_rs2;
            end
            em_reg_write  <= ex_ctrl.reg_write;
            em_mem_to_reg <= ex_ctrl.mem_to_reg;
            em_mem_read   <= ex_ctrl.mem_read;
            em_mem_write  <= ex_ctrl.mem_write;
            em_rd         <= ex_rd;
            mw_reg_write  <= em_reg_write;
            mw_mem_to_reg <= em_mem_to_reg;
            mw_rd         <= em_rd;
            illegal_q     <= illegal_q || id_illegal;
        end
    end

    function automatic logic [1:0] fwd_sel(input logic      em_wr,
                                           input reg_addr_t em_dst,
                                           input logic      mw_wr,
                                           input reg_addr_t mw_dst,
                                           input reg_addr_t src);
        if (em_wr && (em_dst != '0) && (em_dst == src))      return FWD_EX_MEM;
        else if (mw_wr && (mw_dst != '0) && (mw_dst == src)) return FWD_MEM_WB;
        else                                                 return FWD_RF;
    endfunction

    assign fwd_a_o = fwd_sel(em_reg_write, em_rd, mw_reg_write, mw_rd, ex_rs1);
    assign fwd_b_o = fwd_sel(em_reg_write, em_rd, mw_reg_write, mw_rd, ex_rs2);

    assign pc_write_o      = !stall;
    assign if_id_write_o   = !stall;
    assign if_id_flush_o   = flush;
    assign ex_alu_src_o    = ex_ctrl.alu_src;
    assign ex_alu_op_o     = ALU_OP_WIDTH'(ex_ctrl.alu_op);
    assign ex_branch_o     = ex_ctrl.branch;
    assign ex_jump_o       = ex_ctrl.jump;
    assign mem_read_o      = em_mem_read;
    assign mem_write_o     = em_mem_write;
    assign wb_reg_write_o  = mw_reg_write;
    assign wb_mem_to_reg_o = mw_mem_to_reg;
    assign wb_rd_o         = mw_rd;
    assign illegal_o       = illegal_q;

endmodule
